dmem_boot_loader: RTL and testbench

DMEM_BOOT_LOADER -- requirements
Module: dmem_boot_loader

---
 rtl/dmem_boot_loader.sv | 154 +++++++++++++++
 tb/tb_dmem_boot_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_boot_loader.sv
// Boot loader: receives a length-prefixed byte stream and writes it into data memory
// through the boot port while holding the CPU off. Define BOOT_CSUM_EN for a trailing checksum byte.
module dmem_boot_loader #(
    parameter logic [12:0] BASE_DEFAULT = 13'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        base_sel,
    input  logic [12:0] base_addr,
    input  logic [7:0]  rx_data,
    input  logic        rx_vld,
    output logic        rx_rdy,
    output logic        debug,
    output logic [12:0] boot_addr,
    output logic [7:0]  boot_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [12:0] byte_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
`ifdef BOOT_CSUM_EN
        S_CSUM   = 3'd4,
`endif
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // State entered once the last payload byte (or an empty length) has been taken
`ifdef BOOT_CSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t      state_q, state_d;
    logic [12:0] base_q;
    logic [12:0] len_q;
    logic [12:0] byte_cnt_q;
    logic [12:0] boot_addr_q;
    logic [7:0]  boot_data_q;
    logic        debug_q;
    logic        cpu_hold_q;
    logic        load;
    logic        accept;
    logic [12:0] cnt_inc;
    logic [12:0] len_full;
`ifdef BOOT_CSUM_EN
    logic [7:0]  sum_q;
    logic [7:0]  sum_next;
    assign sum_next = sum_q + rx_data;
`endif

    assign load     = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    assign accept   = rx_vld && rx_rdy;
    assign cnt_inc  = byte_cnt_q + 13'd1;
    assign len_full = {rx_data[4:0], len_q[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN_LO;
            S_LEN_LO: if (accept) state_d = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if (rx_data[7:5] != 3'b000) state_d = S_ERR;
                    else if (len_full == 13'd0) state_d = S_TAIL;
                    else                        state_d = S_DATA;
                end
            end
            S_DATA: if (accept && cnt_inc == len_q) state_d = S_TAIL;
`ifdef BOOT_CSUM_EN
            S_CSUM: if (accept) state_d = (sum_next == 8'h00) ? S_DONE : S_ERR;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_rdy = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        case (state_q)
`ifdef BOOT_CSUM_EN
            S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: begin
`else
            S_LEN_LO, S_LEN_HI, S_DATA: begin
`endif
                rx_rdy = 1'b1;
                busy   = 1'b1;
            end
            S_DONE:  done = 1'b1;
            S_ERR:   err  = 1'b1;
            default: ;
        endcase
    end

    // Boot-port write is registered so address and data are stable for the whole strobe cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= 13'd0;
            len_q       <= 13'd0;
            byte_cnt_q  <= 13'd0;
            boot_addr_q <= 13'd0;
            boot_data_q <= 8'd0;
            debug_q     <= 1'b0;
            cpu_hold_q  <= 1'b1;
`ifdef BOOT_CSUM_EN
            sum_q       <= 8'd0;
`endif
        end else begin
            debug_q    <= 1'b0;
            cpu_hold_q <= (state_d != S_IDLE) && (state_d != S_DONE);
            if (load) begin
                base_q     <= base_sel ? base_addr : BASE_DEFAULT;
                byte_cnt_q <= 13'd0;
`ifdef BOOT_CSUM_EN
                sum_q      <= 8'd0;
`endif
            end
            if (accept && state_q == S_LEN_LO) len_q[7:0]  <= rx_data;
            if (accept && state_q == S_LEN_HI) len_q[12:8] <= rx_data[4:0];
            if (accept && state_q == S_DATA) begin
                debug_q     <= 1'b1;
                boot_addr_q <= base_q + byte_cnt_q;
                boot_data_q <= rx_data;
                byte_cnt_q  <= cnt_inc;
`ifdef BOOT_CSUM_EN
                sum_q       <= sum_next;
`endif
            end
        end
    end

    assign debug     = debug_q;
    assign boot_addr = boot_addr_q;
    assign boot_data = boot_data_q;
    assign cpu_hold  = cpu_hold_q;
    assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_dmem_boot_loader.sv
// Directed bench for dmem_boot_loader; expectations follow the build's BOOT_CSUM_EN setting.
module tb_dmem_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        base_sel;
    logic [12:0] base_addr;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic        rx_rdy;
    logic        debug;
    logic [12:0] boot_addr;
    logic [7:0]  boot_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [12:0] byte_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [20:0] wq[$];

    dmem_boot_loader #(.BASE_DEFAULT(13'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_sel(base_sel),
        .base_addr(base_addr), .rx_data(rx_data), .rx_vld(rx_vld),
        .rx_rdy(rx_rdy), .debug(debug), .boot_addr(boot_addr),
        .boot_data(boot_data), .cpu_hold(cpu_hold), .busy(busy),
        .done(done), .err(err), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    // Memory-side view: record every boot-port write
    always @(negedge clk) if (debug === 1'b1) wq.push_back({boot_addr, boot_data});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rdy"},   rx_rdy,    0);
        chk({tag, "_dbg"},   debug,     0);
        chk({tag, "_busy"},  busy,      0);
        chk({tag, "_done"},  done,      0);
        chk({tag, "_err"},   err,       0);
        chk({tag, "_addr"},  boot_addr, 0);
        chk({tag, "_data"},  boot_data, 0);
        chk({tag, "_cnt"},   byte_cnt,  0);
        chk({tag, "_hold"},  cpu_hold,  1);
    endtask

    // Entered and left at posedge+1
    task automatic start_load(input logic sel, input logic [12:0] addr);
        base_sel = sel; base_addr = addr; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        logic got;
        repeat (gap) begin @(posedge clk); #1; end
        rx_data = b; rx_vld = 1'b1; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); got = rx_rdy;
            @(posedge clk); #1;
        end
        rx_vld = 1'b0;
        chk("send_accept", got, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_sel = 1'b0; base_addr = 13'd0;
        rx_data = 8'd0; rx_vld = 1'b0;
        #12;
        chk_reset("rst0");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_hold", cpu_hold, 0);
        chk("rel_rdy",  rx_rdy,   0);

        // Default base, three bytes
        start_load(1'b0, 13'h1234);
        chk("t1_busy", busy, 1);
        chk("t1_hold", cpu_hold, 1);
        chk("t1_rdy",  rx_rdy, 1);
        send(8'h03, 0); send(8'h00, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
`ifdef BOOT_CSUM_EN
        send(8'hCD, 0);
        chk("t1_err", err, 1);
`else
        chk("t1_done", done, 1);
        chk("t1_hold_done", cpu_hold, 0);
        chk("t1_busy_done", busy, 0);
`endif
        chk("t1_cnt", byte_cnt, 3);
        @(posedge clk); #1;
        chk("t1_dbg_off", debug, 0);
        chk("t1_nwr", wq.size(), 3);
        chk("t1_w0", wq[0], {13'd0, 8'h11});
        chk("t1_w1", wq[1], {13'd1, 8'h22});
        chk("t1_w2", wq[2], {13'd2, 8'h33});
        wq.delete();

        // Alternate base with wrap past 8191
        start_load(1'b1, 13'd8190);
        chk("t2_done_clr", done, 0);
        send(8'h03, 0); send(8'h00, 1);
        send(8'hAA, 0); send(8'hBB, 2); send(8'hCC, 0);
`ifdef BOOT_CSUM_EN
        send(8'hCD, 0);
        chk("t2_err", err, 1);
`else
        chk("t2_done", done, 1);
`endif
        @(posedge clk); #1;
        chk("t2_nwr", wq.size(), 3);
        chk("t2_w0", wq[0], {13'd8190, 8'hAA});
        chk("t2_w1", wq[1], {13'd8191, 8'hBB});
        chk("t2_w2", wq[2], {13'd0,    8'hCC});
        wq.delete();

        // Bad checksum byte: rejected with csum, not consumed without it
        start_load(1'b0, 13'd0);
        send(8'h02, 0); send(8'h00, 0); send(8'h01, 0); send(8'h02, 0);
`ifdef BOOT_CSUM_EN
        send(8'h00, 0);
        chk("t3_err",  err, 1);
        chk("t3_done", done, 0);
        chk("t3_hold", cpu_hold, 1);
`else
        rx_data = 8'h00; rx_vld = 1'b1;
        @(negedge clk);
        chk("t3_rdy", rx_rdy, 0);
        repeat (2) begin @(posedge clk); #1; end
        rx_vld = 1'b0;
        chk("t3_done", done, 1);
        chk("t3_err",  err, 0);
        chk("t3_hold", cpu_hold, 0);
`endif
        chk("t3_nwr", wq.size(), 2);
        wq.delete();

        // Illegal high length bits
        start_load(1'b0, 13'd0);
        send(8'h00, 0); send(8'h20, 0);
        chk("t4_err",  err, 1);
        chk("t4_hold", cpu_hold, 1);
        chk("t4_rdy",  rx_rdy, 0);
        @(posedge clk); #1;
        chk("t4_nwr", wq.size(), 0);

        // Zero length
        start_load(1'b0, 13'd0);
        chk("t5_err_clr", err, 0);
        send(8'h00, 0); send(8'h00, 0);
`ifdef BOOT_CSUM_EN
        send(8'h00, 0);
`endif
        chk("t5_done", done, 1);
        chk("t5_cnt",  byte_cnt, 0);
        @(posedge clk); #1;
        chk("t5_nwr", wq.size(), 0);

        // Gapped stream, ignored start mid-load, then reset after two data bytes
        start_load(1'b0, 13'd0);
        send(8'h05, $urandom_range(0, 2));
        send(8'h00, $urandom_range(0, 2));
        send(8'hA1, $urandom_range(0, 2));
        base_sel = 1'b1; base_addr = 13'h0100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t6_busy", busy, 1);
        chk("t6_cnt",  byte_cnt, 1);
        send(8'hB2, $urandom_range(0, 2));
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset("t6_rst");
        chk("t6_nwr", wq.size(), 2);
        chk("t6_w0", wq[0], {13'd0, 8'hA1});
        chk("t6_w1", wq[1], {13'd1, 8'hB2});
        repeat (2) begin @(posedge clk); #1; end
        chk("t6_dbg_hold", debug, 0);
        chk("t6_nwr2", wq.size(), 2);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_rel_hold", cpu_hold, 0);
        chk("t6_rel_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
